// File: rtl/ram_io_responder.sv
// Purpose: byte-serial RAM / memory-mapped I/O responder behind the CPU memory controller's RAM port.
// Latency: read data appears on d_out one cycle after the address; writes and pushes land at the sampling edge.
// Backpressure: rdy_in low freezes controller side effects and d_out; TX drains on io_tx_ready and RX fills on io_rx_valid/io_rx_ready.
//
// Ports:
//   clk_in, rst_in             single clock, synchronous active-high reset
//   rdy_in, r_or_w, a_in, d_in controller request (r_or_w 1 = write), sampled every cycle
//   d_out                      registered read data
//   io_tx_data/valid/ready     TX FIFO drain side (consumer handshake)
//   io_rx_data/valid/ready     RX FIFO fill side (producer handshake)
//   io_buffer_full             TX occupancy at or above depth-2, used by the top to gate rdy_in
//   program_end                sticky halt flag, set by a write to 0x30004

// Purpose: circular byte FIFO shared by the TX and RX paths.
// Latency: push visible at the head one cycle later; head is combinational from the read pointer.
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle, otherwise dropped.
module ram_io_fifo #(
  parameter int LOG = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic [7:0]   push_dat,
  input  logic         pop,
  output logic [7:0]   head_dat,
  output logic         empty,
  output logic         full,
  output logic [LOG:0] count
);

  localparam int DEPTH = 1 << LOG;

  logic [7:0]     mem [DEPTH];
  logic [LOG-1:0] wr_ptr;
  logic [LOG-1:0] rd_ptr;
  logic [LOG:0]   cnt;
  logic           push_ok;
  logic           pop_ok;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (LOG+1)'(DEPTH));
  assign count    = cnt;
  // An empty FIFO never pops, so a same-cycle push is not forwarded.
  assign pop_ok   = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign push_ok  = push && (!full || pop_ok);
  assign head_dat = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (LOG+1)'(push_ok) - (LOG+1)'(pop_ok);
    end
  end

  // Storage has no reset; the empty flag masks stale entries.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_LOG   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        r_or_w,
  input  logic [31:0] a_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        io_buffer_full,
  output logic        program_end
);

  localparam int DEPTH = 1 << FIFO_LOG;

  logic [7:0] ram [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  io_sel;
  logic [15:0]           io_off;
  logic                  req_fifo;
  logic                  req_ctrl;

  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_empty;
  logic                  tx_full;
  logic [FIFO_LOG:0]     tx_count;
  logic                  tx_drop;
  logic                  tx_ovf;

  logic                  rx_push;
  logic                  rx_pop;
  logic [7:0]            rx_head;
  logic                  rx_empty;
  logic                  rx_full;
  logic [FIFO_LOG:0]     unused_rx_count;

  logic                  ram_we;
  logic                  halt_wr;
  logic [7:0]            io_rdata;
  logic                  unused_addr;

  // Window decode: bits 17:16 == 2'b11 is I/O, everything else is RAM.
  assign io_sel      = (a_in[17:16] == 2'b11);
  assign io_off      = a_in[15:0];
  assign req_fifo    = io_sel && (io_off == 16'h0000);
  assign req_ctrl    = io_sel && (io_off == 16'h0004);
  assign ram_idx     = a_in[ADDR_WIDTH-1:0];
  assign unused_addr = ^a_in[31:18];

  // Controller-side effects, all gated by rdy_in.
  assign ram_we  = !rst_in && rdy_in && r_or_w && !io_sel;
  assign halt_wr = rdy_in && r_or_w && req_ctrl;
  assign tx_push = rdy_in && r_or_w && req_fifo;
  // Every read cycle at the FIFO address pops; the FIFO ignores pops when empty.
  assign rx_pop  = rdy_in && !r_or_w && req_fifo;

  // TX drain runs regardless of rdy_in.
  assign tx_pop  = io_tx_valid && io_tx_ready;
  // Overflow only when the push finds no slot even after a same-cycle drain.
  assign tx_drop = tx_push && tx_full && !tx_pop;

  // Ready includes the slot freed by a same-cycle pop so the producer's
  // handshake matches what the FIFO actually accepts when full.
  assign io_rx_ready = !rx_full || rx_pop;
  assign rx_push     = io_rx_valid && io_rx_ready && rdy_in;

  assign io_tx_valid    = !tx_empty;
  assign io_buffer_full = (tx_count >= (FIFO_LOG+1)'(DEPTH - 2));

  ram_io_fifo #(.LOG(FIFO_LOG)) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (tx_push),
    .push_dat (d_in),
    .pop      (io_tx_ready),
    .head_dat (io_tx_data),
    .empty    (tx_empty),
    .full     (tx_full),
    .count    (tx_count)
  );

  ram_io_fifo #(.LOG(FIFO_LOG)) u_rx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (rx_push),
    .push_dat (io_rx_data),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (unused_rx_count)
  );

  always_comb begin
    io_rdata = 8'h00;
    if (req_fifo) begin
      io_rdata = rx_head;
    end else if (req_ctrl) begin
      io_rdata = {5'b0, tx_ovf, tx_full, !rx_empty};
    end
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= d_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      d_out       <= 8'h00;
      tx_ovf      <= 1'b0;
      program_end <= 1'b0;
    end else if (rdy_in) begin
      // d_out only moves on read cycles; writes leave the last read value.
      if (!r_or_w) d_out <= io_sel ? io_rdata : ram[ram_idx];
      if (tx_drop) tx_ovf <= 1'b1;
      if (halt_wr) program_end <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        r_or_w = 1'b0;
  logic [31:0] a_in = 32'h30008;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic [7:0]  io_rx_data = 8'h00;
  logic        io_rx_valid = 1'b0;
  logic        io_rx_ready;
  logic        io_buffer_full;
  logic        program_end;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  ram_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .r_or_w         (r_or_w),
    .a_in           (a_in),
    .d_in           (d_in),
    .d_out          (d_out),
    .io_tx_data     (io_tx_data),
    .io_tx_valid    (io_tx_valid),
    .io_tx_ready    (io_tx_ready),
    .io_rx_data     (io_rx_data),
    .io_rx_valid    (io_rx_valid),
    .io_rx_ready    (io_rx_ready),
    .io_buffer_full (io_buffer_full),
    .program_end    (program_end)
  );

  // Reference model: byte map for RAM, queues for the FIFOs.
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  bit         ovf_m;
  bit         pe_m;
  logic [7:0] dout_m;

  function automatic bit rx_pop_req();
    return rdy_in && !r_or_w && (a_in[17:16] == 2'b11) && (a_in[15:0] == 16'h0000) && (rxq.size() > 0);
  endfunction

  task automatic model_step();
    bit io;
    logic [15:0] off;
    int idx;
    bit draining;
    bit popping;
    bit taking;
    if (rst_in) begin
      txq.delete();
      rxq.delete();
      ovf_m  = 0;
      pe_m   = 0;
      dout_m = 8'h00;
      return;
    end
    io       = (a_in[17:16] == 2'b11);
    off      = a_in[15:0];
    idx      = int'(a_in[16:0]);
    draining = (txq.size() > 0) && io_tx_ready;
    popping  = rx_pop_req();
    taking   = io_rx_valid && rdy_in && ((rxq.size() - int'(popping)) < 8);
    if (rdy_in && !r_or_w) begin
      if (!io)                 dout_m = ram_m.exists(idx) ? ram_m[idx] : 8'hxx;
      else if (off == 16'h0)   dout_m = (rxq.size() > 0) ? rxq[0] : 8'h00;
      else if (off == 16'h4)   dout_m = {5'b0, ovf_m, txq.size() == 8, rxq.size() != 0};
      else                     dout_m = 8'h00;
    end
    if (draining) void'(txq.pop_front());
    if (rdy_in && r_or_w && io && off == 16'h0) begin
      if (txq.size() < 8) txq.push_back(d_in);
      else ovf_m = 1;
    end
    if (popping) void'(rxq.pop_front());
    if (taking)  rxq.push_back(io_rx_data);
    if (rdy_in && r_or_w && !io) ram_m[idx] = d_in;
    if (rdy_in && r_or_w && io && off == 16'h4) pe_m = 1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [31:0] a, input logic [7:0] d);
    r_or_w = rw;
    a_in   = a;
    d_in   = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'h30008, 8'h00);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; io_rx_valid = 1'b0; io_tx_ready = 1'b0;
    idle();
    cycle();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; io_rx_valid = 1'b1; io_rx_data = 8'h11; io_tx_ready = 1'b0;
    drive(1'b1, 32'h30000, 8'hEE);
    cycle();
    cycle();
    rst_in = 1'b0; io_rx_valid = 1'b0;
    idle();
    #1;
    n_checks++; if (d_out !== 8'h00) begin n_fail++; $display("FAIL reset_d_out: got %h want 00", d_out); end
    n_checks++; if (io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", io_tx_valid); end
    n_checks++; if (io_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", io_tx_data); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_buffer_full: got %b want 0", io_buffer_full); end
    n_checks++; if (io_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", io_rx_ready); end
    n_checks++; if (program_end !== 1'b0) begin n_fail++; $display("FAIL reset_program_end: got %b want 0", program_end); end
  endtask

  task automatic test_ram_rw();
    rdy_in = 1'b1;
    drive(1'b1, 32'h00011, 8'h3C); cycle();
    drive(1'b1, 32'h00010, 8'hA5); cycle();
    drive(1'b0, 32'h00010, 8'h00); cycle();
    n_checks++; if (d_out !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_10: got %h want a5", d_out); end
    drive(1'b0, 32'h00011, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h3C) begin n_fail++; $display("FAIL ram_rd_11: got %h want 3c", d_out); end
    drive(1'b1, 32'h00012, 8'h77); cycle();
    drive(1'b0, 32'h00012, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h77) begin n_fail++; $display("FAIL ram_rd_after_wr: got %h want 77", d_out); end
    rdy_in = 1'b0;
    drive(1'b1, 32'h00012, 8'h88); cycle();
    drive(1'b0, 32'h00010, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h77) begin n_fail++; $display("FAIL rdy_low_hold: got %h want 77", d_out); end
    rdy_in = 1'b1;
    drive(1'b0, 32'h00012, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h77) begin n_fail++; $display("FAIL rdy_low_no_write: got %h want 77", d_out); end
  endtask

  task automatic test_word_order();
    logic [7:0] w [4];
    w = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), w[i]); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h100 + 32'(i), 8'h00); cycle();
      n_checks++; if (d_out !== w[i]) begin n_fail++; $display("FAIL word_order[%0d]: got %h want %h", i, d_out, w[i]); end
    end
  endtask

  task automatic test_tx_fill();
    do_reset();
    io_tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 32'h30000, 8'h40 + 8'(k)); cycle();
      n_checks++; if (io_buffer_full !== (k >= 6)) begin n_fail++; $display("FAIL tx_buffer_full after %0d: got %b want %b", k, io_buffer_full, k >= 6); end
    end
    n_checks++; if ({io_tx_valid, io_tx_data} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL tx_head_stalled: got %b/%h want 1/41", io_tx_valid, io_tx_data); end
    drive(1'b0, 32'h30004, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h06) begin n_fail++; $display("FAIL tx_status_ovf: got %h want 06", d_out); end
    idle();
    io_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) rdy_in = 1'b0;
      #1;
      n_checks++; if ({io_tx_valid, io_tx_data} !== {1'b1, 8'h41 + 8'(k)}) begin n_fail++; $display("FAIL tx_drain[%0d]: got %b/%h want 1/%h", k, io_tx_valid, io_tx_data, 8'h41 + 8'(k)); end
      cycle();
    end
    rdy_in = 1'b1; io_tx_ready = 1'b0;
    n_checks++; if ({io_tx_valid, io_tx_data} !== 9'h000) begin n_fail++; $display("FAIL tx_drained: got %b/%h want 0/00", io_tx_valid, io_tx_data); end
    drive(1'b0, 32'h30004, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h04) begin n_fail++; $display("FAIL tx_ovf_sticky: got %h want 04", d_out); end
  endtask

  task automatic test_tx_simul();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h30000, 8'h50 + 8'(k)); cycle();
    end
    drive(1'b1, 32'h30000, 8'h58);
    io_tx_ready = 1'b1;
    cycle();
    io_tx_ready = 1'b0;
    drive(1'b0, 32'h30004, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h02) begin n_fail++; $display("FAIL tx_full_push_pop_status: got %h want 02", d_out); end
    idle();
    io_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (io_tx_data !== 8'h51 + 8'(k)) begin n_fail++; $display("FAIL tx_simul_drain[%0d]: got %h want %h", k, io_tx_data, 8'h51 + 8'(k)); end
      cycle();
    end
    io_tx_ready = 1'b0;
  endtask

  task automatic test_rx_path();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h01, 8'h31, 8'h32, 8'h00};
    do_reset();
    rdy_in = 1'b0; io_rx_valid = 1'b1; io_rx_data = 8'h99;
    cycle(); cycle();
    rdy_in = 1'b1; io_rx_valid = 1'b0;
    drive(1'b0, 32'h30004, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h00) begin n_fail++; $display("FAIL rx_stall_rdy_low: got %h want 00", d_out); end
    idle();
    io_rx_valid = 1'b1; io_rx_data = 8'h31; cycle();
    io_rx_data = 8'h32; cycle();
    io_rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 0) ? 32'h30004 : 32'h30000, 8'h00); cycle();
      n_checks++; if (d_out !== exp_rd[i]) begin n_fail++; $display("FAIL rx_read[%0d]: got %h want %h", i, d_out, exp_rd[i]); end
    end
    drive(1'b0, 32'h30004, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h00) begin n_fail++; $display("FAIL rx_status_empty: got %h want 00", d_out); end
    io_rx_valid = 1'b1; io_rx_data = 8'h7E;
    drive(1'b0, 32'h30000, 8'h00); cycle();
    io_rx_valid = 1'b0;
    n_checks++; if (d_out !== 8'h00) begin n_fail++; $display("FAIL rx_empty_no_forward: got %h want 00", d_out); end
    drive(1'b0, 32'h30000, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h7E) begin n_fail++; $display("FAIL rx_empty_push_kept: got %h want 7e", d_out); end
  endtask

  task automatic test_rx_full();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      io_rx_valid = 1'b1; io_rx_data = 8'h60 + 8'(i); cycle();
    end
    io_rx_valid = 1'b0;
    #1;
    n_checks++; if (io_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", io_rx_ready); end
    io_rx_valid = 1'b1; io_rx_data = 8'h6F;
    drive(1'b0, 32'h30000, 8'h00);
    #1;
    n_checks++; if (io_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_full_pop_ready: got %b want 1", io_rx_ready); end
    cycle();
    io_rx_valid = 1'b0;
    n_checks++; if (d_out !== 8'h60) begin n_fail++; $display("FAIL rx_full_pop_data: got %h want 60", d_out); end
    idle();
    #1;
    n_checks++; if (io_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_count_stays_full: got %b want 0", io_rx_ready); end
    for (int k = 0; k < 9; k++) begin
      want = (k < 7) ? 8'h61 + 8'(k) : (k == 7) ? 8'h6F : 8'h00;
      drive(1'b0, 32'h30000, 8'h00); cycle();
      n_checks++; if (d_out !== want) begin n_fail++; $display("FAIL rx_full_drain[%0d]: got %h want %h", k, d_out, want); end
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    drive(1'b1, 32'h30004, 8'h00); cycle();
    n_checks++; if (program_end !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", program_end); end
    idle();
    for (int i = 0; i < 5; i++) begin
      rdy_in = i[0];
      cycle();
    end
    rdy_in = 1'b1;
    n_checks++; if (program_end !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", program_end); end
    drive(1'b0, 32'h00100, 8'h00); cycle();
    n_checks++; if (d_out !== 8'h78) begin n_fail++; $display("FAIL halt_pre_rd: got %h want 78", d_out); end
    drive(1'b1, 32'h30000, 8'h55); cycle();
    n_checks++; if (io_tx_valid !== 1'b1) begin n_fail++; $display("FAIL halt_tx_queued: got %b want 1", io_tx_valid); end
    rst_in = 1'b1;
    drive(1'b1, 32'h30000, 8'h66); cycle();
    rst_in = 1'b0;
    idle();
    n_checks++; if (program_end !== 1'b0) begin n_fail++; $display("FAIL rst_program_end: got %b want 0", program_end); end
    n_checks++; if ({io_tx_valid, io_tx_data} !== 9'h000) begin n_fail++; $display("FAIL rst_tx: got %b/%h want 0/00", io_tx_valid, io_tx_data); end
    n_checks++; if (d_out !== 8'h00) begin n_fail++; $display("FAIL rst_d_out: got %h want 00", d_out); end
    cycle();
    n_checks++; if (io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_write_discarded: got %b want 0", io_tx_valid); end
  endtask

  task automatic test_random();
    logic [7:0] exp_head;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 8'($urandom)); cycle();
    end
    for (int n = 0; n < 2000; n++) begin
      rst_in      = ($urandom_range(0, 99) == 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      r_or_w      = 1'($urandom);
      d_in        = 8'($urandom);
      io_tx_ready = ($urandom_range(0, 2) == 0);
      io_rx_valid = 1'($urandom);
      io_rx_data  = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    a_in = 32'h30000;
        2:       a_in = (r_or_w && $urandom_range(0, 7) != 0) ? 32'h30008 : 32'h30004;
        3:       a_in = 32'h30008;
        default: a_in = 32'h200 + 32'($urandom_range(0, 15));
      endcase
      #1;
      exp_head = (txq.size() > 0) ? txq[0] : 8'h00;
      n_checks++; if (d_out !== dout_m) begin n_fail++; $display("FAIL rnd_d_out @%0d: got %h want %h", n, d_out, dout_m); end
      n_checks++; if (io_tx_valid !== (txq.size() > 0)) begin n_fail++; $display("FAIL rnd_tx_valid @%0d: got %b want %b", n, io_tx_valid, txq.size() > 0); end
      n_checks++; if (io_tx_data !== exp_head) begin n_fail++; $display("FAIL rnd_tx_data @%0d: got %h want %h", n, io_tx_data, exp_head); end
      n_checks++; if (io_buffer_full !== (txq.size() >= 6)) begin n_fail++; $display("FAIL rnd_buffer_full @%0d: got %b want %b", n, io_buffer_full, txq.size() >= 6); end
      n_checks++; if (io_rx_ready !== ((rxq.size() - int'(rx_pop_req())) < 8)) begin n_fail++; $display("FAIL rnd_rx_ready @%0d: got %b", n, io_rx_ready); end
      n_checks++; if (program_end !== pe_m) begin n_fail++; $display("FAIL rnd_program_end @%0d: got %b want %b", n, program_end, pe_m); end
      cycle();
    end
    rst_in = 1'b0; rdy_in = 1'b1; io_rx_valid = 1'b0; io_tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_word_order();
    test_tx_fill();
    test_tx_simul();
    test_rx_path();
    test_rx_full();
    test_halt_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
